// File: rtl/fc_pkg.sv
// Shared types, sizes and helpers for the fully-connected post-processing stages.
package fc_pkg;

  localparam int unsigned FC1_NUM_NEURONS = 84;
  localparam int unsigned FC1_ADDR_WIDTH  = 7;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    STREAM,
    START,
    WAIT_NEXT
  } fc1_stream_state_t;

  // Largest positive two's-complement value representable in data_width bits.
  function automatic logic [63:0] sat_max(input int unsigned data_width);
    return (64'd1 << (data_width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/bias_relu_sat.sv
// Bias add followed by ReLU with positive saturation; purely combinational.
module bias_relu_sat
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));

  logic [DATA_WIDTH:0] sum_c;

  // One extra bit holds the true sign; negatives clamp to 0, overflow clamps to max.
  always_comb begin
    sum_c = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    y     = sum_c[DATA_WIDTH-1:0];
    if (sum_c[DATA_WIDTH]) begin
      y = '0;
    end else if (sum_c[DATA_WIDTH-1]) begin
      y = SAT_MAX;
    end
  end

endmodule

// File: rtl/fc1_bias_relu_stream.sv
// FC1 post-stage: snapshot FC1 outputs and biases, stream bias+ReLU results into
// the FC2 input memory, then hand off to FC2 and wait for it to finish.
module fc1_bias_relu_stream
  import fc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_NEURONS = FC1_NUM_NEURONS,
  parameter int unsigned ADDR_WIDTH  = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] fc_in,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] bias_in,
  input  logic                              start_from_previous,
  output logic                              end_to_previous,
  output logic [DATA_WIDTH-1:0]             write_data_next,
  output logic [ADDR_WIDTH-1:0]             write_addr_next,
  output logic                              enable_write_next,
  output logic                              start_to_next,
  input  logic                              end_from_next,
  output logic                              busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);

  fc1_stream_state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  eop_q, eop_d;
  logic                  wen_q, wen_d;
  logic                  stn_q, stn_d;
  logic                  busy_q, busy_d;
  logic                  released_c;
  logic [DATA_WIDTH-1:0] act_c;

  logic [DATA_WIDTH-1:0] buf_fc_q   [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] buf_bias_q [NUM_NEURONS];

  // Next-state, index, pending-start tracking and registered output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    released_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_from_previous || pending_q) state_d = CAPTURE;
      end
      CAPTURE: begin
        pending_d = 1'b0;
        idx_d     = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        // eop_q is high only in the first STREAM cycle, before FC1 has been released.
        released_c = !eop_q;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = START;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      START: begin
        released_c = 1'b1;
        state_d    = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        released_c = 1'b1;
        if (end_from_next) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_from_previous && released_c) pending_d = 1'b1;

    eop_d  = (state_q == CAPTURE);
    wen_d  = (state_d == STREAM);
    stn_d  = (state_d == START);
    busy_d = (state_d != IDLE);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      eop_q     <= 1'b0;
      wen_q     <= 1'b0;
      stn_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      eop_q     <= eop_d;
      wen_q     <= wen_d;
      stn_q     <= stn_d;
      busy_q    <= busy_d;
    end
  end

  // Snapshot buffers: loaded once per frame so FC1 may overwrite its outputs.
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) begin
      for (int i = 0; i < int'(NUM_NEURONS); i++) begin
        buf_fc_q[i]   <= fc_in[i*DATA_WIDTH +: DATA_WIDTH];
        buf_bias_q[i] <= bias_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  bias_relu_sat #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bias_relu_sat (
    .a(buf_fc_q[idx_q]),
    .b(buf_bias_q[idx_q]),
    .y(act_c)
  );

  assign end_to_previous   = eop_q;
  assign enable_write_next = wen_q;
  assign start_to_next     = stn_q;
  assign busy              = busy_q;
  assign write_addr_next   = idx_q;
  assign write_data_next   = wen_q ? act_c : '0;

endmodule

// File: tb/tb_fc1_bias_relu_stream.sv
// Scoreboard bench for fc1_bias_relu_stream with a arithmetic reference model.
module tb_fc1_bias_relu_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned NN = 84;
  localparam int unsigned AW = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [NN*DW-1:0] fc_in;
  logic [NN*DW-1:0] bias_in;
  logic            start_from_previous;
  logic            end_to_previous;
  logic [DW-1:0]   write_data_next;
  logic [AW-1:0]   write_addr_next;
  logic            enable_write_next;
  logic            start_to_next;
  logic            end_from_next;
  logic            busy;

  always #5 clk = ~clk;

  fc1_bias_relu_stream #(
    .DATA_WIDTH(DW),
    .NUM_NEURONS(NN),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fc_in(fc_in),
    .bias_in(bias_in),
    .start_from_previous(start_from_previous),
    .end_to_previous(end_to_previous),
    .write_data_next(write_data_next),
    .write_addr_next(write_addr_next),
    .enable_write_next(enable_write_next),
    .start_to_next(start_to_next),
    .end_from_next(end_from_next),
    .busy(busy)
  );

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          nwrites = 0;
  int          eop_count = 0;
  int          stn_count = 0;
  logic [31:0] fc_arr   [NN];
  logic [31:0] bias_arr [NN];

  // Reference: signed add, negatives to zero, clamp at the largest positive word.
  function automatic logic [31:0] ref_act(input logic [31:0] f, input logic [31:0] b);
    longint s;
    s = longint'($signed(f)) + longint'($signed(b));
    if (s < 0) return 32'd0;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    return s[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < int'(NN); i++) begin
      fc_in[i*DW +: DW]   = fc_arr[i];
      bias_in[i*DW +: DW] = bias_arr[i];
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < int'(NN); i++) begin
      e.addr = i;
      e.data = ref_act(fc_arr[i], bias_arr[i]);
      exp_q.push_back(e);
    end
  endtask

  task automatic randomize_arrays();
    for (int i = 0; i < int'(NN); i++) begin
      case ($urandom_range(0, 3))
        0: begin fc_arr[i] = $urandom; bias_arr[i] = $urandom; end
        1: begin
          fc_arr[i]   = 32'($urandom_range(0, 2000)) - 32'd1000;
          bias_arr[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
        end
        2: begin
          fc_arr[i]   = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
          bias_arr[i] = 32'($urandom_range(0, 511));
        end
        default: begin
          fc_arr[i]   = 32'h8000_0000 + 32'($urandom_range(0, 255));
          bias_arr[i] = $urandom;
        end
      endcase
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < int'(NN); i++) begin
      fc_in[i*DW +: DW]   = $urandom;
      bias_in[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges until end_to_previous, bounded.
  task automatic wait_eop(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!end_to_previous && n < 200);
  endtask

  // Counts negedges until start_to_next, bounded.
  task automatic wait_stn(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start_to_next && n < 300);
  endtask

  task automatic end_pulse();
    tick();
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
    @(negedge clk);
    check("busy_after_end", 64'(busy), 64'(0));
  endtask

  // Monitor: compare every write against the scoreboard; count handshake pulses.
  always @(negedge clk) begin
    exp_t e;
    if (end_to_previous) eop_count++;
    if (start_to_next) stn_count++;
    if (enable_write_next) begin
      nwrites++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addr %0d data %0h, expected no write", write_addr_next, write_data_next);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(write_addr_next), 64'(e.addr));
        check("write_data", 64'(write_data_next), 64'(e.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    reset = 1'b0;
    start_from_previous = 1'b0;
    end_from_next = 1'b0;
    fc_in = '0;
    bias_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wen", 64'(enable_write_next), 64'(0));
    check("rst_eop", 64'(end_to_previous), 64'(0));
    check("rst_stn", 64'(start_to_next), 64'(0));
    check("rst_wdata", 64'(write_data_next), 64'(0));
    check("rst_waddr", 64'(write_addr_next), 64'(0));
    tick();
    reset = 1'b1;
    tick();

    // Run A: ramp data with boundary neurons; inputs change mid-stream.
    for (int i = 0; i < int'(NN); i++) begin
      fc_arr[i]   = 32'(i);
      bias_arr[i] = 32'd10;
    end
    fc_arr[5] = -32'sd100;       bias_arr[5] = 32'd40;
    fc_arr[7] = 32'h7FFF_FFF0;   bias_arr[7] = 32'h20;
    fc_arr[8] = 32'h8000_0000;   bias_arr[8] = 32'hFFFF_FFFF;
    pack_inputs();
    push_expected();
    start_from_previous = 1'b1;
    wait_eop(n);
    check("eop_latency_A", 64'(n), 64'(3));
    start_from_previous = 1'b0;
    scramble_inputs();
    wait_stn(n);
    check("stn_latency_A", 64'(n), 64'(84));
    check("writes_A", 64'(nwrites), 64'(84));
    check("queue_empty_A", 64'(exp_q.size()), 64'(0));
    repeat (5) @(negedge clk);
    check("wait_busy_A", 64'(busy), 64'(1));
    check("stn_once_A", 64'(start_to_next), 64'(0));
    end_pulse();
    check("eop_count_A", 64'(eop_count), 64'(1));
    check("stn_count_A", 64'(stn_count), 64'(1));

    // Run B: random data, then a short start pulse in WAIT_NEXT must not be lost.
    randomize_arrays();
    pack_inputs();
    push_expected();
    nwrites = 0;
    tick();
    start_from_previous = 1'b1;
    wait_eop(n);
    check("eop_latency_B", 64'(n), 64'(3));
    start_from_previous = 1'b0;
    randomize_arrays();
    pack_inputs();
    wait_stn(n);
    check("stn_latency_B", 64'(n), 64'(84));
    check("writes_B", 64'(nwrites), 64'(84));
    push_expected();
    nwrites = 0;
    tick();
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
    repeat (3) tick();
    end_from_next = 1'b1;
    @(negedge clk);
    check("busy_at_W", 64'(busy), 64'(1));
    tick();
    end_from_next = 1'b0;
    @(negedge clk);
    check("idle_gap", 64'(busy), 64'(0));
    @(negedge clk);
    check("pending_capture", 64'(busy), 64'(1));
    check("pending_no_eop_yet", 64'(end_to_previous), 64'(0));
    @(negedge clk);
    check("pending_eop", 64'(end_to_previous), 64'(1));
    scramble_inputs();
    wait_stn(n);
    check("stn_latency_B2", 64'(n), 64'(84));
    check("writes_B2", 64'(nwrites), 64'(84));
    check("queue_empty_B2", 64'(exp_q.size()), 64'(0));
    end_pulse();
    check("eop_count_B", 64'(eop_count), 64'(3));
    check("stn_count_B", 64'(stn_count), 64'(3));

    // Run C: end_from_next during STREAM is ignored.
    randomize_arrays();
    pack_inputs();
    push_expected();
    nwrites = 0;
    tick();
    start_from_previous = 1'b1;
    wait_eop(n);
    check("eop_latency_C", 64'(n), 64'(3));
    start_from_previous = 1'b0;
    repeat (10) @(negedge clk);
    end_from_next = 1'b1;
    @(negedge clk);
    end_from_next = 1'b0;
    wait_stn(n);
    check("stn_latency_C", 64'(n), 64'(73));
    check("writes_C", 64'(nwrites), 64'(84));
    repeat (4) @(negedge clk);
    check("wait_holds_C", 64'(busy), 64'(1));
    end_pulse();

    // Run D: reset in the middle of the stream.
    randomize_arrays();
    pack_inputs();
    push_expected();
    nwrites = 0;
    tick();
    start_from_previous = 1'b1;
    wait_eop(n);
    start_from_previous = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 120 && !found; k++) begin
      if (enable_write_next && write_addr_next == AW'(40)) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_idx40", 64'(found), 64'(1));
    #1;
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_wen", 64'(enable_write_next), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_waddr", 64'(write_addr_next), 64'(0));
    check("rst_mid_wdata", 64'(write_data_next), 64'(0));
    tick();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst", 64'(busy), 64'(0));
    check("writes_D", 64'(nwrites), 64'(41));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
